clock_mode_ctrl: RTL

- Sequencing controller for the six-digit HH:MM:SS clock datapath.
- Owns the timekeeping counters and runs them from a prescaled 1 Hz tick in RUN mode.
- Arbitrates the two push-buttons between digit selection and digit increment in SET mode.
- Schedules the beeper for key-press clicks and the optional hourly chime. Feeds the 7-segment display logic directly.

---
 rtl/clock_mode_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: sequencing controller for the HH:MM:SS clock datapath.
// Runs the time counters from a prescaled 1 Hz tick in RUN, lets the two
// buttons select/increment digits in SET, and schedules the beeper.
// Optional hourly chime: define CLOCK_MODE_CTRL_CHIME_EN.
//
// Button handshake: inputs are raw levels; each debounced button produces a
// one-cycle press pulse that is consumed in the cycle it is high (no stall).

// Two-flop synchroniser plus debounce filter for one push-button.
// IDLE is the released level: IDLE=1 -> press on the falling filtered edge,
// IDLE=0 -> press on the rising filtered edge.
module clock_mode_ctrl_debounce #(
   parameter int   CYC  = 20,
   parameter logic IDLE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CYC - 1);

   logic s1, s2, s_d, level, level_d;
   logic [CW-1:0] cnt;

   // Synchronise, restart the stability count on any change, follow when stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= IDLE;
         s2      <= IDLE;
         s_d     <= IDLE;
         level   <= IDLE;
         level_d <= IDLE;
         cnt     <= '0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         s_d     <= s2;
         level_d <= level;
         if (s2 != s_d)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         else
            level <= s2;
      end
   end

   assign press = IDLE ? (~level & level_d) : (level & ~level_d);
endmodule

module clock_mode_ctrl #(
   parameter int CLK_HZ       = 1000,
   parameter int DEBOUNCE_CYC = 20,
   parameter int BEEP_CYC     = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       btn_next,
   input  logic       btn_add,
   output logic [1:0] hour_h,
   output logic [3:0] hour_l,
   output logic [2:0] min_h,
   output logic [3:0] min_l,
   output logic [2:0] sec_h,
   output logic [3:0] sec_l,
   output logic [1:0] edit_pos,
   output logic       edit_active,
   output logic       sec_tick,
   output logic       beep
);
   localparam int PW = $clog2(CLK_HZ + 1);
   localparam int BW = $clog2(4 * BEEP_CYC + 1);
   localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
   localparam logic [BW-1:0] BEEP_SHORT = BW'(BEEP_CYC);

   typedef enum logic [1:0] {ST_RUN, ST_SET, ST_COMMIT} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [BW-1:0] beep_cnt;
   logic          key_s1, key_s2;
   logic          next_p, add_p;
   logic          roll, chime_req;

   clock_mode_ctrl_debounce #(.CYC(DEBOUNCE_CYC), .IDLE(1'b1)) u_next (
      .clk(clk), .rst_n(rst_n), .raw(btn_next), .press(next_p));
   clock_mode_ctrl_debounce #(.CYC(DEBOUNCE_CYC), .IDLE(1'b0)) u_add (
      .clk(clk), .rst_n(rst_n), .raw(btn_add), .press(add_p));

   // Mode request is a slow level switch: synchronise only, no debounce
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= 1'b0;
         key_s2 <= 1'b0;
      end else begin
         key_s1 <= key_mode;
         key_s2 <= key_s1;
      end
   end

   assign roll = (presc == PRESC_MAX);

`ifdef CLOCK_MODE_CTRL_CHIME_EN
   localparam logic [BW-1:0] BEEP_LONG = BW'(4 * BEEP_CYC);
   // Hourly chime fires on the MM:SS 59:59 -> 00:00 rollover in RUN only
   assign chime_req = (state == ST_RUN) && roll && (min_h == 3'd5) && (min_l == 4'd9)
                      && (sec_h == 3'd5) && (sec_l == 4'd9);
`else
   assign chime_req = 1'b0;
`endif

   assign beep = (beep_cnt != '0);

   // Beep counter: chime beats click, any new click retriggers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         beep_cnt <= '0;
`ifdef CLOCK_MODE_CTRL_CHIME_EN
      else if (chime_req)
         beep_cnt <= BEEP_LONG;
`endif
      else if (next_p || add_p)
         beep_cnt <= BEEP_SHORT;
      else if (beep_cnt != '0)
         beep_cnt <= beep_cnt - 1'b1;
   end

   // Mode FSM with timekeeping and digit editing; all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         presc       <= '0;
         hour_h      <= '0;
         hour_l      <= '0;
         min_h       <= '0;
         min_l       <= '0;
         sec_h       <= '0;
         sec_l       <= '0;
         edit_pos    <= '0;
         edit_active <= 1'b0;
         sec_tick    <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         case (state)
            ST_RUN: begin
               if (roll) begin
                  presc    <= '0;
                  sec_tick <= 1'b1;
                  if (sec_l != 4'd9) sec_l <= sec_l + 4'd1;
                  else begin
                     sec_l <= 4'd0;
                     if (sec_h != 3'd5) sec_h <= sec_h + 3'd1;
                     else begin
                        sec_h <= 3'd0;
                        if (min_l != 4'd9) min_l <= min_l + 4'd1;
                        else begin
                           min_l <= 4'd0;
                           if (min_h != 3'd5) min_h <= min_h + 3'd1;
                           else begin
                              min_h <= 3'd0;
                              if (hour_h == 2'd2 && hour_l == 4'd3) begin
                                 hour_h <= 2'd0;
                                 hour_l <= 4'd0;
                              end else if (hour_l == 4'd9) begin
                                 hour_l <= 4'd0;
                                 hour_h <= hour_h + 2'd1;
                              end else
                                 hour_l <= hour_l + 4'd1;
                           end
                        end
                     end
                  end
               end else
                  presc <= presc + 1'b1;
               if (key_s2) begin
                  state       <= ST_SET;
                  edit_active <= 1'b1;
               end
            end
            ST_SET: begin
               presc <= '0;
               sec_h <= 3'd0;
               sec_l <= 4'd0;
               // Add uses the current edit_pos even when next fires together
               if (add_p) begin
                  case (edit_pos)
                     2'd0: min_l <= (min_l == 4'd9) ? 4'd0 : min_l + 4'd1;
                     2'd1: min_h <= (min_h == 3'd5) ? 3'd0 : min_h + 3'd1;
                     2'd2: begin
                        if ((hour_h == 2'd2 && hour_l >= 4'd3) || hour_l == 4'd9)
                           hour_l <= 4'd0;
                        else
                           hour_l <= hour_l + 4'd1;
                     end
                     default: begin
                        if (hour_h == 2'd2)
                           hour_h <= 2'd0;
                        else begin
                           hour_h <= hour_h + 2'd1;
                           // Entering the 20s: clamp an out-of-range units digit
                           if (hour_h == 2'd1 && hour_l > 4'd3)
                              hour_l <= 4'd0;
                        end
                     end
                  endcase
               end
               if (next_p)
                  edit_pos <= edit_pos + 2'd1;
               if (!key_s2) begin
                  state       <= ST_COMMIT;
                  edit_active <= 1'b0;
               end
            end
            ST_COMMIT: begin
               if (hour_h == 2'd2 && hour_l > 4'd3)
                  hour_l <= 4'd0;
               edit_pos <= 2'd0;
               presc    <= '0;
               state    <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end
endmodule
